// File: rtl/m_btb_upd_if.sv
// Update-side bus of the BTB controller: branch reports in, BTB write port and status out.
interface m_btb_upd_if;
    logic        w_flush;
    logic        w_br_valid;
    logic [31:0] w_br_pc;
    logic        w_br_taken;
    logic [31:0] w_br_tgt;
    logic        w_br_hit;
    logic [31:0] w_br_pred;
    logic [4:0]  w_wa;
    logic        w_we;
    logic [57:0] w_wd;
    logic        w_busy;
    logic        w_drop;
    logic [15:0] w_drops;

    // Execute-stage side: issues reports and flushes, observes the write port.
    modport master (
        output w_flush, w_br_valid, w_br_pc, w_br_taken, w_br_tgt, w_br_hit, w_br_pred,
        input  w_wa, w_we, w_wd, w_busy, w_drop, w_drops
    );

    // Controller side.
    modport slave (
        input  w_flush, w_br_valid, w_br_pc, w_br_taken, w_br_tgt, w_br_hit, w_br_pred,
        output w_wa, w_we, w_wd, w_busy, w_drop, w_drops
    );
endinterface

// File: rtl/m_btb_upd.sv
// BTB update controller: filters resolved-branch reports into allocate/invalidate
// writes, buffers them in a small FIFO and drains one write per cycle. Sweeps all
// 32 entries to zero after reset or flush.
module m_btb_upd #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         w_clock,
    input  logic         w_rst,
    m_btb_upd_if.slave   bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned TAG_W   = 25;
    localparam int unsigned TGT_W   = 32;
    localparam int unsigned WD_W    = 1 + TAG_W + TGT_W;
    localparam int unsigned CNT_W   = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(31);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic [IDX_W-1:0] wa;
        logic [WD_W-1:0]  wd;
    } upd_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    upd_t             fifo_q [DEPTH];
    logic             busy_q;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] drops_q, drops_d;

    logic             qual_c;
    upd_t             new_c;
    upd_t             head_c;
    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic [AW-1:0]    push_slot_c;

    // PC bits [1:0] carry no index or tag information.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^bus.w_br_pc[1:0];

    // Report filter: allocate on a missed/mispredicted taken branch, invalidate a
    // stale hit on a not-taken branch, otherwise nothing to do.
    always_comb begin
        qual_c   = 1'b0;
        new_c.wa = bus.w_br_pc[6:2];
        new_c.wd = '0;
        if (bus.w_br_valid) begin
            if (bus.w_br_taken) begin
                qual_c = !bus.w_br_hit || (bus.w_br_pred != bus.w_br_tgt);
                new_c.wd = {1'b1, bus.w_br_pc[31:7], bus.w_br_tgt};
            end else begin
                qual_c = bus.w_br_hit;
            end
        end
    end

    // FIFO status from pointer compare; the extra MSB separates full from empty.
    always_comb begin
        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        head_c  = fifo_q[rd_ptr_q[AW-1:0]];
        pop_c   = (state_q == ST_RUN) && !empty_c && !bus.w_flush;
    end

    // BTB write port: sweep zeros in INIT, FIFO head in RUN. A flush cycle writes
    // nothing since the queued head is being discarded.
    always_comb begin
        bus.w_we = 1'b0;
        bus.w_wa = '0;
        bus.w_wd = '0;
        if (!w_rst && !bus.w_flush) begin
            if (state_q == ST_INIT) begin
                bus.w_we = 1'b1;
                bus.w_wa = idx_q;
            end else if (!empty_c) begin
                bus.w_we = 1'b1;
                bus.w_wa = head_c.wa;
                bus.w_wd = head_c.wd;
            end
        end
    end

    assign bus.w_busy  = busy_q;
    assign bus.w_drop  = drop_q;
    assign bus.w_drops = drops_q;

    // Next-state: sweep sequencing, FIFO pointers, enqueue/drop decisions.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        drop_d      = 1'b0;
        drops_d     = drops_q;
        push_c      = 1'b0;
        push_slot_c = wr_ptr_q[AW-1:0];

        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (bus.w_flush) begin
            // Restart the sweep; a same-cycle report lands in the emptied FIFO.
            state_d  = ST_INIT;
            idx_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            if (qual_c) begin
                push_c      = 1'b1;
                push_slot_c = '0;
                wr_ptr_d    = PW'(1);
            end
        end else if (qual_c) begin
            if (!full_c || pop_c) begin
                push_c   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                drop_d = 1'b1;
                if (drops_q != CNT_MAX) begin
                    drops_d = drops_q + CNT_W'(1);
                end
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge w_clock) begin
        if (w_rst) begin
            state_q  <= ST_INIT;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b1;
            drop_q   <= 1'b0;
            drops_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= (state_d == ST_INIT);
            drop_q   <= drop_d;
            drops_q  <= drops_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge w_clock) begin
        if (!w_rst && push_c) begin
            fifo_q[push_slot_c] <= new_c;
        end
    end
endmodule

// File: tb/tb_m_btb_upd.sv
// Directed bench for the BTB update controller with a small BTB memory model.
module tb_m_btb_upd;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [57:0] btb [32];

    m_btb_upd_if bus ();

    m_btb_upd #(.DEPTH(4)) dut (
        .w_clock (clk),
        .w_rst   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference BTB array fed by the write port.
    always @(posedge clk) begin
        if (bus.w_we) btb[bus.w_wa] <= bus.w_wd;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic report(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic hit, input logic [31:0] pred);
        bus.w_br_valid = 1'b1;
        bus.w_br_pc    = pc;
        bus.w_br_taken = taken;
        bus.w_br_tgt   = tgt;
        bus.w_br_hit   = hit;
        bus.w_br_pred  = pred;
    endtask

    task automatic idle();
        bus.w_br_valid = 1'b0;
        bus.w_flush    = 1'b0;
    endtask

    // Step through a sweep until w_busy falls; count any non-zero write seen.
    task automatic run_sweep(input string tag);
        int n = 0;
        int nz = 0;
        while (bus.w_busy && n < 40) begin
            if (bus.w_we && bus.w_wd != 58'd0) nz++;
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(bus.w_busy), 64'd0);
        chk({tag, "_nz"}, 64'(nz), 64'd0);
    endtask

    initial begin
        logic [57:0] e;
        rst = 1'b1;
        idle();
        report(32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        bus.w_br_valid = 1'b0;

        // Reset: one cycle, outputs quiet while reset is high.
        tick();
        chk("rst_we", 64'(bus.w_we), 64'd0);
        chk("rst_busy", 64'(bus.w_busy), 64'd1);
        chk("rst_drop", 64'(bus.w_drop), 64'd0);
        chk("rst_drops", 64'(bus.w_drops), 64'd0);

        // Initial sweep: 32 zero writes at indices 0..31.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("sw_we%0d", i), 64'(bus.w_we), 64'd1);
            chk($sformatf("sw_wa%0d", i), 64'(bus.w_wa), 64'(i));
            chk($sformatf("sw_wd%0d", i), 64'(bus.w_wd), 64'd0);
            chk($sformatf("sw_busy%0d", i), 64'(bus.w_busy), 64'd1);
            tick();
        end
        chk("sw_end_we", 64'(bus.w_we), 64'd0);
        chk("sw_end_busy", 64'(bus.w_busy), 64'd0);

        // Allocate: taken, BTB miss.
        report(32'h0000_1084, 1'b1, 32'h0000_2000, 1'b0, 32'd0);
        tick();
        idle();
        chk("alloc_we", 64'(bus.w_we), 64'd1);
        chk("alloc_wa", 64'(bus.w_wa), 64'd1);
        chk("alloc_wd", 64'(bus.w_wd), 64'({1'b1, 25'h21, 32'h0000_2000}));
        tick();
        chk("alloc_idle_we", 64'(bus.w_we), 64'd0);
        e = btb[1];
        chk("lookup_hit", 64'(e[57] && e[56:32] == 25'h21), 64'd1);
        chk("lookup_tgt", 64'(e[31:0]), 64'h2000);

        // Invalidate: not taken, BTB hit.
        report(32'h0000_1084, 1'b0, 32'h0000_1088, 1'b1, 32'h0000_2000);
        tick();
        idle();
        chk("inv_we", 64'(bus.w_we), 64'd1);
        chk("inv_wa", 64'(bus.w_wa), 64'd1);
        chk("inv_wd", 64'(bus.w_wd), 64'd0);
        tick();
        e = btb[1];
        chk("lookup_inv", 64'(e[57]), 64'd0);

        // Correct prediction: no action.
        report(32'h0000_1084, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_2000);
        tick();
        idle();
        chk("noop_we", 64'(bus.w_we), 64'd0);
        chk("noop_drop", 64'(bus.w_drop), 64'd0);

        // Flush, then six reports during the sweep: four queued, two dropped.
        bus.w_flush = 1'b1;
        #1;
        chk("flush_we", 64'(bus.w_we), 64'd0);
        tick();
        idle();
        chk("fl_busy", 64'(bus.w_busy), 64'd1);
        chk("fl_wa", 64'(bus.w_wa), 64'd0);
        for (int k = 0; k < 6; k++) begin
            report(32'h0000_1000 + 32'(k * 4), 1'b1, 32'h0000_3000 + 32'(k), 1'b0, 32'd0);
            tick();
            chk($sformatf("ovf_drop%0d", k), 64'(bus.w_drop), (k >= 4) ? 64'd1 : 64'd0);
        end
        idle();
        chk("ovf_drops", 64'(bus.w_drops), 64'd2);
        tick();
        chk("ovf_drop_end", 64'(bus.w_drop), 64'd0);
        run_sweep("ovf_sweep");
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_we%0d", k), 64'(bus.w_we), 64'd1);
            chk($sformatf("ovf_wa%0d", k), 64'(bus.w_wa), 64'(k));
            chk($sformatf("ovf_wd%0d", k), 64'(bus.w_wd),
                64'({1'b1, 25'h20, 32'h0000_3000 + 32'(k)}));
            tick();
        end
        chk("ovf_empty_we", 64'(bus.w_we), 64'd0);
        chk("ovf_drops_keep", 64'(bus.w_drops), 64'd2);

        // Flush in RUN with two entries still queued plus a same-cycle report.
        bus.w_flush = 1'b1;
        #1;
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            report(32'h0000_2000 + 32'(k * 4), 1'b1, 32'h0000_4000 + 32'(k), 1'b0, 32'd0);
            tick();
        end
        idle();
        run_sweep("q_sweep");
        chk("q_wa0", 64'(bus.w_wa), 64'd0);
        tick();
        chk("q_wa1", 64'(bus.w_wa), 64'd1);
        tick();
        report(32'h0000_2050, 1'b1, 32'h0000_5555, 1'b0, 32'd0);
        bus.w_flush = 1'b1;
        #1;
        chk("qf_we", 64'(bus.w_we), 64'd0);
        tick();
        idle();
        chk("qf_busy", 64'(bus.w_busy), 64'd1);
        chk("qf_wa", 64'(bus.w_wa), 64'd0);
        run_sweep("qf_sweep");
        chk("qf_new_we", 64'(bus.w_we), 64'd1);
        chk("qf_new_wa", 64'(bus.w_wa), 64'd20);
        chk("qf_new_wd", 64'(bus.w_wd), 64'({1'b1, 25'h40, 32'h0000_5555}));
        tick();
        chk("qf_empty_we", 64'(bus.w_we), 64'd0);

        // Reset mid-sweep at idx 17 together with a report.
        bus.w_flush = 1'b1;
        #1;
        tick();
        idle();
        for (int i = 0; i < 17; i++) tick();
        chk("mr_wa17", 64'(bus.w_wa), 64'd17);
        rst = 1'b1;
        report(32'h0000_3008, 1'b1, 32'h0000_6666, 1'b0, 32'd0);
        #1;
        chk("mr_we", 64'(bus.w_we), 64'd0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("mr_restart_we", 64'(bus.w_we), 64'd1);
        chk("mr_restart_wa", 64'(bus.w_wa), 64'd0);
        chk("mr_busy", 64'(bus.w_busy), 64'd1);
        chk("mr_drops", 64'(bus.w_drops), 64'd0);
        run_sweep("mr_sweep");
        chk("mr_no_write", 64'(bus.w_we), 64'd0);
        tick();
        chk("mr_no_write2", 64'(bus.w_we), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m_btb_upd.md
# m_btb_upd

Update-side controller for the 32-entry direct-mapped branch target buffer, which has one write port (w_wa/w_we/w_wd) and whose entry layout is {valid, tag[24:0], target[31:0]}. The block takes resolved-branch reports from the execute stage and filters them into allocate, invalidate or no-op actions. Accepted actions are buffered in a small FIFO and drained onto the BTB write port at one write per cycle. After reset, and on request, the block also sweeps all 32 entries to zero.

## Interface
- DEPTH, 4: update FIFO depth (power of two, >=2)
- w_clock  in  1  clock; all state changes on posedge
- w_rst  in  1  reset, synchronous, active-high
- w_flush  in  1  pulse: restart invalidation sweep, discard queued updates
- w_br_valid  in  1  resolved branch report this cycle
- w_br_pc  in  32  PC of resolved branch
- w_br_taken  in  1  actual direction
- w_br_tgt  in  32  actual target
- w_br_hit  in  1  BTB hit seen at fetch for this branch
- w_br_pred  in  32  BTB target seen at fetch (ignored if !w_br_hit)
- w_wa  out  5  BTB write index
- w_we  out  1  BTB write enable
- w_wd  out  58  BTB write word
- w_busy  out  1  sweep in progress
- w_drop  out  1  one-cycle pulse: report lost, FIFO full
- w_drops  out  16  saturating count of dropped reports

## Operation
- States: INIT (sweep), RUN. Reset state INIT, sweep index 0.
- Reset values: FIFO empty, w_drop=0, w_drops=0, w_we=0. w_we is forced 0 while w_rst=1.
- INIT: each cycle w_we=1, w_wa=idx, w_wd=0, idx++. After idx=31 is written, go to RUN. w_busy=1 throughout INIT.
- RUN: if FIFO is non-empty, w_we=1 with w_wa/w_wd taken from the FIFO head, and the head pops at the clock edge. If the FIFO is empty, w_we=0 and w_wa/w_wd are don't-care (drive 0).
- Report filter, evaluated in the cycle w_br_valid=1:
  - taken and (!hit or pred!=tgt): enqueue {wa=pc[6:2], wd={1'b1, pc[31:7], tgt}}
  - !taken and hit: enqueue {wa=pc[6:2], wd=58'b0} (invalidate)
  - taken, hit, pred==tgt: no action
  - !taken, !hit: no action
- Filtered-out reports never count as drops.
- Enqueue with FIFO full and no pop in the same cycle: report discarded, w_drop=1 next cycle, w_drops increments and saturates at 16'hFFFF.
- Full FIFO with a pop in the same cycle (RUN): push is accepted.
- FIFO is written only during INIT or a burst; in steady RUN its occupancy is <=1.
- w_flush=1 (either state): next state INIT, idx=0, FIFO cleared. Cleared entries are not drops.
- A qualifying report in the same cycle as w_flush is enqueued into the cleared FIFO and is written after the sweep.
- w_flush during INIT restarts the sweep at 0.
- w_rst has priority over w_flush and reports. A report during reset is ignored.
- FIFO pointers are log2(DEPTH)+1 bits wide with wrap-around. Full/empty are decided from the MSB compare.

## Timing
- Reset deasserted at edge E0. Sweep writes idx 0..31 in cycles 1..32 after E0. RUN starts in cycle 33.
- Report latency in RUN with FIFO empty: report in cycle N -> w_we=1 carrying it in cycle N+1 -> BTB memory updated at the end of N+1. A lookup in N+2 sees the new entry.
- Order is preserved. Two reports to the same index are both written, the later one last.
- Reports queued during INIT drain back-to-back from the first RUN cycle, oldest first.
- w_drop and w_drops are updated one edge after the rejected report. w_busy is registered with the state.
- During INIT the FIFO never pops, so at most DEPTH reports survive a sweep.

## Test plan
- Reset 1 cycle, then release -> w_we=1 for exactly 32 cycles with w_wa=0..31 and w_wd=0, w_busy=1 then 0, w_we=0 from cycle 33.
- RUN: report pc=32'h0000_1084, taken, hit=0, tgt=32'h0000_2000 -> next cycle w_wa=5'd1, w_wd={1,25'h21,32'h2000}. A BTB lookup of 32'h1084 two cycles later hits with dout=32'h2000.
- Report pc=32'h1084 not taken, hit=1 -> w_wd=0 at w_wa=1. Report taken, hit=1, pred=tgt=32'h2000 -> w_we stays 0.
- During the sweep, 6 qualifying reports with DEPTH=4 -> 4 queued, w_drop pulses twice, w_drops=2. The 4 queued reports are written in cycles 33..36 in order.
- w_flush in cycle 10 of RUN with 2 queued entries plus a simultaneous report -> sweep restarts at idx 0, the old entries are never written, and the flush-cycle report is written at the first RUN cycle after the sweep.
- w_rst asserted mid-sweep at idx=17 together with a report -> w_we=0 during reset, the sweep restarts at 0, and the report is never written.
